// File: rtl/xcom_pkg.sv
// Shared types and constants for the XCOM command initiator.
// The command record, FSM state encoding and header op-codes live here.
package xcom_pkg;

  typedef struct packed {
    logic        net;
    logic [7:0]  op;
    logic [31:0] dt;
  } xcom_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2,
    ST_ABORT  = 2'd3
  } xcom_state_t;

  // Header op-codes (op[7:4]).
  localparam logic [3:0] OP_SET_ID  = 4'b0000;
  localparam logic [3:0] OP_WFLG    = 4'b0001;
  localparam logic [3:0] OP_WREG    = 4'b0010;
  localparam logic [3:0] OP_WMEM    = 4'b0011;
  localparam logic [3:0] OP_QSYNC   = 4'b1000;
  localparam logic [3:0] OP_AUTO_ID = 4'b1001;
  localparam logic [3:0] OP_QCTRL   = 4'b1011;

endpackage

// File: rtl/xcom_cmd_fifo.sv
// First-word-fall-through command FIFO with flush and overflow flag.
// head always shows the oldest entry; a push while full is dropped.
module xcom_cmd_fifo
  import xcom_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  xcom_cmd_t   push_cmd,
  input  logic        pop,
  input  logic        flush,
  output xcom_cmd_t   head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow
);

  xcom_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign head     = mem[rd_ptr];
  // Flush outranks a push in the same cycle, so neither moves data then.
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign overflow = push && full && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/xcom_cmd_issuer.sv
// XCOM command initiator: queues commands and issues each as a 4-phase
// req/ack handshake on the local or network channel, with per-phase timeout.
module xcom_cmd_issuer
  import xcom_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TMO_CYC  = 1024,
  parameter int ACK_SYNC = 2
) (
  input  logic                     c_clk_i,
  input  logic                     c_rst_i,
  input  logic                     push_i,
  input  logic                     push_net_i,
  input  logic [7:0]               push_op_i,
  input  logic [31:0]              push_dt_i,
  input  logic                     flush_i,
  input  logic                     clr_err_i,
  input  logic                     xcom_rdy_i,
  output logic                     cmd_loc_req_o,
  input  logic                     cmd_loc_ack_i,
  output logic                     cmd_net_req_o,
  input  logic                     cmd_net_ack_i,
  output logic [7:0]               cmd_op_o,
  output logic [31:0]              cmd_dt_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               err_o
);

  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

  xcom_state_t state, state_nx;
  xcom_cmd_t   push_cmd, head;
  logic        empty, overflow, pop;
  logic        loc_ack, net_ack, ack_s;
  logic        sel_net, done_nx, tmo_evt, tmo, next_net;
  logic [15:0] timer;
  logic [1:0]  err;
  logic        loc_req, net_req, done;
  logic [7:0]  op;
  logic [31:0] dt;

  assign push_cmd = '{net: push_net_i, op: push_op_i, dt: push_dt_i};

  xcom_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (c_clk_i),
    .rst      (c_rst_i),
    .push     (push_i),
    .push_cmd (push_cmd),
    .pop      (pop),
    .flush    (flush_i),
    .head     (head),
    .full     (full_o),
    .empty    (empty),
    .count    (count_o),
    .overflow (overflow)
  );

  generate
    if (ACK_SYNC == 0) begin : g_nosync
      assign loc_ack = cmd_loc_ack_i;
      assign net_ack = cmd_net_ack_i;
    end else begin : g_sync
      logic [ACK_SYNC-1:0] loc_sh;
      logic [ACK_SYNC-1:0] net_sh;

      always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
          loc_sh <= '0;
          net_sh <= '0;
        end else begin
          for (int i = ACK_SYNC - 1; i > 0; i--) begin
            loc_sh[i] <= loc_sh[i-1];
            net_sh[i] <= net_sh[i-1];
          end
          loc_sh[0] <= cmd_loc_ack_i;
          net_sh[0] <= cmd_net_ack_i;
        end
      end

      assign loc_ack = loc_sh[ACK_SYNC-1];
      assign net_ack = net_sh[ACK_SYNC-1];
    end
  endgenerate

  assign ack_s = sel_net ? net_ack : loc_ack;
  assign tmo   = (timer >= TMO_LIM);

  // Next-state decode; no issue while done is high keeps transactions apart.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done_nx  = 1'b0;
    tmo_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && xcom_rdy_i && !done) begin
          pop      = 1'b1;
          state_nx = ST_REQ_HI;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          state_nx = ST_REQ_LO;
        end else if (tmo) begin
          tmo_evt  = 1'b1;
          state_nx = ST_ABORT;
        end else begin
          state_nx = ST_REQ_HI;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else if (tmo) begin
          tmo_evt  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_REQ_LO;
        end
      end
      ST_ABORT: begin
        if (!ack_s || tmo) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ABORT;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign next_net = pop ? head.net : sel_net;

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      state   <= ST_IDLE;
      sel_net <= 1'b0;
      op      <= 8'h00;
      dt      <= 32'h0000_0000;
      loc_req <= 1'b0;
      net_req <= 1'b0;
      done    <= 1'b0;
      err     <= 2'b00;
      timer   <= 16'h0000;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (pop) begin
        sel_net <= head.net;
        op      <= head.op;
        dt      <= head.dt;
      end
      loc_req <= (state_nx == ST_REQ_HI) && !next_net;
      net_req <= (state_nx == ST_REQ_HI) && next_net;
      // A fresh error event wins over a simultaneous clear.
      err     <= (clr_err_i ? 2'b00 : err) | {overflow, tmo_evt};
      if (state_nx != state) begin
        timer <= 16'h0000;
      end else if (timer != 16'hFFFF) begin
        timer <= timer + 16'd1;
      end else begin
        timer <= timer;
      end
    end
  end

  assign cmd_loc_req_o = loc_req;
  assign cmd_net_req_o = net_req;
  assign cmd_op_o      = op;
  assign cmd_dt_o      = dt;
  assign empty_o       = empty;
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = done;
  assign err_o         = err;

endmodule

// File: tb/tb_xcom_cmd_issuer.sv
// Directed bench for xcom_cmd_issuer with a registered req/ack responder.
// DUT built with DEPTH=8, TMO_CYC=16, ACK_SYNC=0.
module tb_xcom_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0, push_net = 1'b0;
  logic [7:0]  push_op = 8'h00;
  logic [31:0] push_dt = 32'h0;
  logic        flush = 1'b0, clr_err = 1'b0, rdy = 1'b1;
  logic        loc_req, net_req;
  logic        loc_ack = 1'b0, net_ack = 1'b0;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_dt;
  logic        full, empty, busy, done;
  logic [3:0]  count;
  logic [1:0]  err;

  int compared = 0, mismatched = 0;
  int ack_dly = 0;
  bit never_ack = 1'b0;
  int hi_cnt = 0;
  int done_cnt = 0, loc_hi = 0, net_hi = 0, overlap = 0, cyc = 0;
  int last_issue_cyc = 0, prev_issue_cyc = 0;
  logic prev_req = 1'b0;
  logic [12:0] rec [$];   // {net, count at first req cycle, op}

  int b_done, b_loc, b_net, b_ovl, qb;
  bit ok;

  xcom_cmd_issuer #(.DEPTH(8), .TMO_CYC(16), .ACK_SYNC(0)) dut (
    .c_clk_i       (clk),
    .c_rst_i       (rst),
    .push_i        (push),
    .push_net_i    (push_net),
    .push_op_i     (push_op),
    .push_dt_i     (push_dt),
    .flush_i       (flush),
    .clr_err_i     (clr_err),
    .xcom_rdy_i    (rdy),
    .cmd_loc_req_o (loc_req),
    .cmd_loc_ack_i (loc_ack),
    .cmd_net_req_o (net_req),
    .cmd_net_ack_i (net_ack),
    .cmd_op_o      (cmd_op),
    .cmd_dt_o      (cmd_dt),
    .full_o        (full),
    .empty_o       (empty),
    .count_o       (count),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  // Responder: raises ack ack_dly+1 cycles after req, drops it one cycle after req falls.
  always @(posedge clk) begin
    hi_cnt  <= (loc_req || net_req) ? hi_cnt + 1 : 0;
    loc_ack <= loc_req && !never_ack && (hi_cnt >= ack_dly);
    net_ack <= net_req && !never_ack && (hi_cnt >= ack_dly);
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (loc_req && net_req) overlap <= overlap + 1;
    if (loc_req) loc_hi <= loc_hi + 1;
    if (net_req) net_hi <= net_hi + 1;
    if ((loc_req || net_req) && !prev_req) begin
      rec.push_back({net_req, count, cmd_op});
      prev_issue_cyc <= last_issue_cyc;
      last_issue_cyc <= cyc;
    end
    prev_req <= loc_req || net_req;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic net, input logic [7:0] o, input logic [31:0] d);
    push = 1'b1; push_net = net; push_op = o; push_dt = d;
    step();
    push = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    bit q = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy && empty && !done && !loc_req && !net_req) begin
        q = 1'b1;
        break;
      end
    end
    chk({tag, "_quiet_in_time"}, q, 1);
  endtask

  function automatic logic [12:0] rec_at(input int i);
    if (i < rec.size()) return rec[i];
    else return 13'h1fff;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    // reset state
    chk("rst_loc_req", loc_req, 0);
    chk("rst_net_req", net_req, 0);
    chk("rst_op_dt", {cmd_op, cmd_dt}, 40'h0);
    chk("rst_flags", {full, empty, busy, done}, 4'b0100);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();

    // T1: single local command, ack one cycle after req
    b_done = done_cnt; b_loc = loc_hi; b_net = net_hi;
    push_cmd(1'b0, 8'h21, 32'hDEADBEEF);
    wait_quiet(40, "t1");
    chk("t1_loc_req_cycles", loc_hi - b_loc, 2);
    chk("t1_net_req_cycles", net_hi - b_net, 0);
    chk("t1_done_pulses", done_cnt - b_done, 1);
    chk("t1_op_held", cmd_op, 8'h21);
    chk("t1_dt_held", cmd_dt, 32'hDEADBEEF);
    chk("t1_empty", empty, 1);

    // T2: three queued commands, first ack delayed
    rdy = 1'b0;
    push_cmd(1'b1, 8'h80, 32'h1);
    push_cmd(1'b1, 8'h91, 32'h2);
    push_cmd(1'b0, 8'h32, 32'h3);
    chk("t2_count3", count, 3);
    b_done = done_cnt; b_loc = loc_hi; b_net = net_hi; b_ovl = overlap; qb = rec.size();
    ack_dly = 10;
    rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_cnt > b_done) begin ok = 1'b1; break; end
    end
    chk("t2_first_done_in_time", ok, 1);
    ack_dly = 0;
    wait_quiet(60, "t2");
    chk("t2_issue0", rec_at(qb),     {1'b1, 4'd2, 8'h80});
    chk("t2_issue1", rec_at(qb + 1), {1'b1, 4'd1, 8'h91});
    chk("t2_issue2", rec_at(qb + 2), {1'b0, 4'd0, 8'h32});
    chk("t2_done_pulses", done_cnt - b_done, 3);
    chk("t2_overlap", overlap - b_ovl, 0);
    chk("t2_net_req_cycles", net_hi - b_net, 14);
    chk("t2_loc_req_cycles", loc_hi - b_loc, 2);
    chk("t2_issue_period", last_issue_cyc - prev_issue_cyc, 6);

    // T3: overflow with rdy low, clear coincident with overflow loses
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_cmd(1'b0, 8'(8'h40 + i), 32'(i));
    clr_err = 1'b1;
    push_cmd(1'b0, 8'h48, 32'h8);
    clr_err = 1'b0;
    chk("t3_full", full, 1);
    chk("t3_count8", count, 8);
    chk("t3_err_ovf", err, 2'b10);
    b_done = done_cnt; qb = rec.size();
    rdy = 1'b1;
    wait_quiet(100, "t3");
    chk("t3_done_pulses", done_cnt - b_done, 8);
    chk("t3_first_issue", rec_at(qb),     {1'b0, 4'd7, 8'h40});
    chk("t3_last_issue",  rec_at(qb + 7), {1'b0, 4'd0, 8'h47});
    chk("t3_issue_total", rec.size() - qb, 8);
    chk("t3_err_sticky", err, 2'b10);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_err_cleared", err, 2'b00);

    // T4: ack never rises -> timeout after 16 req cycles, next command proceeds
    never_ack = 1'b1;
    b_done = done_cnt; b_loc = loc_hi;
    push_cmd(1'b0, 8'h11, 32'h5);
    push_cmd(1'b0, 8'h12, 32'h6);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (loc_req) begin ok = 1'b1; break; end
      step();
    end
    chk("t4_req_rise", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!loc_req) begin ok = 1'b1; break; end
      step();
    end
    chk("t4_req_fall", ok, 1);
    chk("t4_req_cycles", loc_hi - b_loc, 16);
    chk("t4_err_tmo", err, 2'b01);
    chk("t4_no_done", done_cnt - b_done, 0);
    chk("t4_busy_abort", busy, 1);
    never_ack = 1'b0;
    wait_quiet(40, "t4");
    chk("t4_next_done", done_cnt - b_done, 1);
    chk("t4_next_op", rec_at(rec.size() - 1), {1'b0, 4'd0, 8'h12});
    chk("t4_total_req_cycles", loc_hi - b_loc, 18);

    // T5: push and pop together at count 1, then flush during REQ_HI
    rdy = 1'b0;
    ack_dly = 8;
    b_done = done_cnt;
    push_cmd(1'b0, 8'h51, 32'h1);
    qb = rec.size();
    rdy = 1'b1;
    push_cmd(1'b0, 8'h52, 32'h2);
    chk("t5_push_pop_count", count, 1);
    push_cmd(1'b0, 8'h53, 32'h3);
    push_cmd(1'b0, 8'h54, 32'h4);
    push_cmd(1'b0, 8'h55, 32'h5);
    chk("t5_count4", count, 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_empty", {empty, count}, {1'b1, 4'd0});
    chk("t5_inflight_req", {busy, loc_req, cmd_op}, {1'b1, 1'b1, 8'h51});
    wait_quiet(40, "t5");
    chk("t5_done", done_cnt - b_done, 1);
    chk("t5_issues", rec.size() - qb, 1);

    // T6: reset while in REQ_HI
    push_cmd(1'b0, 8'h61, 32'h7);
    push_cmd(1'b0, 8'h62, 32'h8);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (loc_req) begin ok = 1'b1; break; end
      step();
    end
    chk("t6_req_high", {ok, count, err}, {1'b1, 4'd1, 2'b01});
    rst = 1'b1;
    step();
    chk("t6_rst_req", {loc_req, net_req}, 2'b00);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_err", err, 2'b00);
    chk("t6_rst_busy_empty", {busy, empty, done}, 3'b010);
    rst = 1'b0;
    repeat (3) step();
    chk("t6_idle_after", {busy, loc_req}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
